// File: rtl/fu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fu_pkg : shared widths and the issue_t record for FU issue arbitration   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package fu_pkg;

  localparam int INST_ID_BITS = 6;
  localparam int PRN_BITS     = 6;
  localparam int MAX_OPERANDS = 3;

  typedef struct packed {
    logic [INST_ID_BITS-1:0]               inst_id;
    logic [31:0]                           inst;
    logic [MAX_OPERANDS-1:0][63:0]         op;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] out_prn;
    logic [63:0]                           pc;
  } issue_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter : round-robin picker; ptr holds last grant, searched last     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
  parameter  int N        = 4,
  localparam int IDX_BITS = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic                en,
  output logic [N-1:0]        gnt,
  output logic [IDX_BITS-1:0] gnt_idx
);

  logic [IDX_BITS-1:0] ptr_q, ptr_d;
  logic [IDX_BITS-1:0] cand;
  logic                found;

  always_comb begin
    found   = 1'b0;
    gnt_idx = ptr_q;
    cand    = ptr_q;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_BITS'((int'(ptr_q) + k) % N);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt = '0;
    if (en && found) gnt[gnt_idx] = 1'b1;
    ptr_d = (en && found) ? gnt_idx : ptr_q;
  end

  // Reset to the last index so requester 0 has first priority.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= IDX_BITS'(N - 1);
    else     ptr_q <= ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/fu_issue_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fu_issue_arbiter : shares one FU among NUM_REQ requesters with credits   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fu_issue_arbiter #(
  parameter  int NUM_REQ        = 4,
  parameter  int INST_ID_BITS   = fu_pkg::INST_ID_BITS,
  parameter  int PRN_BITS       = fu_pkg::PRN_BITS,
  parameter  int MAX_OPERANDS   = fu_pkg::MAX_OPERANDS,
  parameter  int MAX_INFLIGHT   = 4,
  parameter  bit CHECK_PROTOCOL = 1'b1,
  localparam int CNT_BITS       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [NUM_REQ-1:0]                               req_valid,
  output logic [NUM_REQ-1:0]                               req_ready,
  input  logic [NUM_REQ-1:0][INST_ID_BITS-1:0]             req_inst_id,
  input  logic [NUM_REQ-1:0][31:0]                         req_inst,
  input  logic [NUM_REQ-1:0][MAX_OPERANDS-1:0][63:0]       req_op,
  input  logic [NUM_REQ-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] req_out_prn,
  input  logic [NUM_REQ-1:0][63:0]                         req_pc,
  output logic                                             fu_inst_valid,
  output logic [INST_ID_BITS-1:0]                          fu_inst_id,
  output logic [31:0]                                      fu_inst,
  output logic [MAX_OPERANDS-1:0][63:0]                    fu_op,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            fu_out_prn,
  output logic [63:0]                                      fu_pc,
  input  logic                                             fu_out_valid,
  output logic [CNT_BITS-1:0]                              inflight,
  output logic                                             busy
);
  import fu_pkg::*;

  localparam int IDX_BITS = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]  gnt;
  logic [IDX_BITS-1:0] gnt_idx;
  logic                can_issue;
  logic                grant;
  logic [CNT_BITS-1:0] inflight_q, inflight_d;
  logic                fu_inst_valid_q, fu_inst_valid_d;
  issue_t              issue_q, issue_d;

  assign can_issue = inflight_q < CNT_BITS'(MAX_INFLIGHT);

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (can_issue & ~rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign grant     = |gnt;

  always_comb begin
    issue_d = issue_q;
    if (grant) begin
      issue_d.inst_id = req_inst_id[gnt_idx];
      issue_d.inst    = req_inst[gnt_idx];
      issue_d.op      = req_op[gnt_idx];
      issue_d.out_prn = req_out_prn[gnt_idx];
      issue_d.pc      = req_pc[gnt_idx];
    end
    fu_inst_valid_d = grant;
    // A completion with no credit outstanding is dropped rather than wrapping.
    inflight_d = inflight_q;
    if (grant && !fu_out_valid)
      inflight_d = inflight_q + CNT_BITS'(1);
    else if (!grant && fu_out_valid && inflight_q != '0)
      inflight_d = inflight_q - CNT_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q      <= '0;
      fu_inst_valid_q <= 1'b0;
      issue_q         <= '0;
    end else begin
      inflight_q      <= inflight_d;
      fu_inst_valid_q <= fu_inst_valid_d;
      issue_q         <= issue_d;
    end
  end

  generate
    if (CHECK_PROTOCOL) begin : g_protocol_check
      always_ff @(posedge clk) begin
        if (!rst) assert (!(fu_out_valid && inflight_q == '0));
      end
    end
  endgenerate

  assign fu_inst_valid = fu_inst_valid_q;
  assign fu_inst_id    = issue_q.inst_id;
  assign fu_inst       = issue_q.inst;
  assign fu_op         = issue_q.op;
  assign fu_out_prn    = issue_q.out_prn;
  assign fu_pc         = issue_q.pc;
  assign inflight      = inflight_q;
  assign busy          = (inflight_q != '0) | fu_inst_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fu_issue_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fu_issue_arbiter : scoreboard bench for fu_issue_arbiter              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fu_issue_arbiter;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [3:0]            req_valid = '0;
  logic [3:0]            req_ready;
  logic [3:0][5:0]       req_inst_id;
  logic [3:0][31:0]      req_inst;
  logic [3:0][2:0][63:0] req_op;
  logic [3:0][2:0][5:0]  req_out_prn;
  logic [3:0][63:0]      req_pc;
  logic                  fu_inst_valid;
  logic [5:0]            fu_inst_id;
  logic [31:0]           fu_inst;
  logic [2:0][63:0]      fu_op;
  logic [2:0][5:0]       fu_out_prn;
  logic [63:0]           fu_pc;
  logic                  fu_out_valid = 1'b0;
  logic [2:0]            inflight;
  logic                  busy;

  int n_checks = 0;
  int n_fail   = 0;

  fu_issue_arbiter #(.NUM_REQ(4), .MAX_INFLIGHT(4), .CHECK_PROTOCOL(1'b0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_inst_id(req_inst_id), .req_inst(req_inst), .req_op(req_op),
    .req_out_prn(req_out_prn), .req_pc(req_pc), .fu_inst_valid(fu_inst_valid),
    .fu_inst_id(fu_inst_id), .fu_inst(fu_inst), .fu_op(fu_op),
    .fu_out_prn(fu_out_prn), .fu_pc(fu_pc), .fu_out_valid(fu_out_valid),
    .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]       id;
    logic [31:0]      inst;
    logic [2:0][63:0] op;
    logic [2:0][5:0]  prn;
    logic [63:0]      pc;
  } exp_t;

  exp_t sb[$];
  int   m_ptr  = 3;
  int   m_infl = 0;
  bit   exp_v  = 1'b0;

  function automatic int pick(logic [3:0] v, int p);
    int c;
    for (int k = 1; k <= 4; k++) begin
      c = (p + k) % 4;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Reference model: decides grants from its own pointer and credit count.
  always @(posedge clk) begin
    int   w;
    bit   g;
    exp_t e;
    if (rst) begin
      m_ptr  <= 3;
      m_infl <= 0;
      exp_v  <= 1'b0;
      sb.delete();
    end else begin
      w = pick(req_valid, m_ptr);
      g = (m_infl < 4) && (w >= 0);
      exp_v <= g;
      if (g) begin
        m_ptr  <= w;
        e.id   = req_inst_id[w];
        e.inst = req_inst[w];
        e.op   = req_op[w];
        e.prn  = req_out_prn[w];
        e.pc   = req_pc[w];
        sb.push_back(e);
      end
      if (g && !fu_out_valid)                  m_infl <= m_infl + 1;
      else if (!g && fu_out_valid && m_infl > 0) m_infl <= m_infl - 1;
    end
  end

  always @(negedge clk) begin
    logic [3:0] er;
    int         w;
    exp_t       e;
    w  = pick(req_valid, m_ptr);
    er = '0;
    if (!rst && m_infl < 4 && w >= 0) er[w] = 1'b1;
    n_checks++;
    if (req_ready !== er) begin
      n_fail++;
      $display("FAIL req_ready @%0t: got %b expected %b", $time, req_ready, er);
    end
    if (!rst) begin
      n_checks++;
      if (inflight !== 3'(m_infl)) begin
        n_fail++;
        $display("FAIL inflight @%0t: got %0d expected %0d", $time, inflight, m_infl);
      end
      n_checks++;
      if (fu_inst_valid !== exp_v) begin
        n_fail++;
        $display("FAIL fu_inst_valid @%0t: got %b expected %b", $time, fu_inst_valid, exp_v);
      end
      n_checks++;
      if (busy !== (m_infl != 0 || exp_v)) begin
        n_fail++;
        $display("FAIL busy @%0t: got %b expected %b", $time, busy, (m_infl != 0 || exp_v));
      end
      if (exp_v) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_empty @%0t: got no entry expected one", $time);
        end else begin
          e = sb.pop_front();
          if (fu_inst_id !== e.id || fu_inst !== e.inst || fu_op !== e.op ||
              fu_out_prn !== e.prn || fu_pc !== e.pc) begin
            n_fail++;
            $display("FAIL issue_fields @%0t: got id=%h pc=%h op=%h expected id=%h pc=%h op=%h",
                     $time, fu_inst_id, fu_pc, fu_op, e.id, e.pc, e.op);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields();
    for (int i = 0; i < 4; i++) begin
      req_inst_id[i] = 6'(10 + i);
      req_inst[i]    = $urandom;
      req_pc[i]      = {$urandom, $urandom};
      for (int j = 0; j < 3; j++) begin
        req_op[i][j]      = {$urandom, $urandom};
        req_out_prn[i][j] = 6'($urandom);
      end
    end
  endtask

  task automatic drain();
    int n;
    req_valid = '0;
    n = 0;
    while (m_infl > 0 && n < 10) begin
      fu_out_valid = 1'b1;
      cyc();
      n++;
    end
    fu_out_valid = 1'b0;
    cyc();
    @(negedge clk);
    n_checks++;
    if (inflight !== 3'd0) begin
      n_fail++;
      $display("FAIL drain: inflight got %0d expected 0", inflight);
    end
    cyc();
  endtask

  task automatic test_reset();
    set_fields();
    rst = 1'b1;
    req_valid = '1;
    repeat (2) cyc();
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0000 || fu_inst_valid !== 1'b0 || inflight !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%b valid=%b inflight=%0d expected 0000/0/0",
               req_ready, fu_inst_valid, inflight);
    end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL first_grant: got %b expected 0001", req_ready);
    end
    cyc();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_r;
    fu_out_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_r = 4'b0001 << (k % 4);
      n_checks++;
      if (req_ready !== exp_r || fu_inst_id !== 6'(10 + (k - 1) % 4)) begin
        n_fail++;
        $display("FAIL rr_order k=%0d: got ready=%b id=%0d expected ready=%b id=%0d",
                 k, req_ready, fu_inst_id, exp_r, 10 + (k - 1) % 4);
      end
      cyc();
    end
    fu_out_valid = 1'b0;
    drain();
  endtask

  task automatic test_credit_limit();
    int grants;
    set_fields();
    req_valid = '1;
    grants = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) grants++;
      cyc();
    end
    @(negedge clk);
    n_checks++;
    if (grants != 4 || inflight !== 3'd4 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL credit_limit: got grants=%0d inflight=%0d ready=%b expected 4/4/0000",
               grants, inflight, req_ready);
    end
    cyc();
    fu_out_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL credit_no_comb_path: got %b expected 0000", req_ready);
    end
    cyc();
    fu_out_valid = 1'b0;
    grants = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) grants++;
      cyc();
    end
    n_checks++;
    if (grants != 1) begin
      n_fail++;
      $display("FAIL credit_refill: got %0d grants expected 1", grants);
    end
    drain();
  endtask

  task automatic test_simultaneous();
    set_fields();
    req_valid = '1;
    repeat (3) cyc();
    fu_out_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (inflight !== 3'd3 || req_ready === 4'b0000) begin
      n_fail++;
      $display("FAIL simul_pre: got inflight=%0d ready=%b expected 3 and a grant",
               inflight, req_ready);
    end
    cyc();
    fu_out_valid = 1'b0;
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (inflight !== 3'd3) begin
      n_fail++;
      $display("FAIL simul_net: got inflight=%0d expected 3", inflight);
    end
    cyc();
    drain();
  endtask

  task automatic test_skip_idle();
    logic [63:0]      pc1, pc3;
    logic [2:0][63:0] op1, op3;
    set_fields();
    pc1 = req_pc[1]; pc3 = req_pc[3];
    op1 = req_op[1]; op3 = req_op[3];
    req_valid = 4'b0010;
    cyc();
    req_valid = 4'b1010;
    fu_out_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL skip_grant3: got %b expected 1000", req_ready);
    end
    cyc();
    @(negedge clk);
    n_checks++;
    if (fu_inst_valid !== 1'b1 || fu_pc !== pc3 || fu_op !== op3 || req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL skip_fields3: got v=%b pc=%h ready=%b expected 1 pc=%h ready=0010",
               fu_inst_valid, fu_pc, req_ready, pc3);
    end
    cyc();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (fu_inst_valid !== 1'b1 || fu_pc !== pc1 || fu_op !== op1) begin
      n_fail++;
      $display("FAIL skip_fields1: got v=%b pc=%h expected 1 pc=%h", fu_inst_valid, fu_pc, pc1);
    end
    cyc();
    fu_out_valid = 1'b0;
    drain();
  endtask

  task automatic test_spurious();
    req_valid = '0;
    fu_out_valid = 1'b1;
    cyc();
    fu_out_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (inflight !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_sat: got inflight=%0d busy=%b expected 0/0", inflight, busy);
    end
    cyc();
  endtask

  task automatic test_midstream_reset();
    set_fields();
    req_valid = '1;
    repeat (2) cyc();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (inflight !== 3'd2) begin
      n_fail++;
      $display("FAIL mid_pre: got inflight=%0d expected 2", inflight);
    end
    cyc();
    rst = 1'b1;
    req_valid = '1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (inflight !== 3'd0 || fu_inst_valid !== 1'b0 || req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_reset: got inflight=%0d v=%b ready=%b expected 0/0/0001",
               inflight, fu_inst_valid, req_ready);
    end
    cyc();
    drain();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_credit_limit();
    test_simultaneous();
    test_skip_idle();
    test_spurious();
    test_midstream_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
